// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed multiply (radix-2 Booth) and signed divide
// (restoring division on magnitudes). Both take 32 iterations, one per clock.
// A request is captured on the edge that samples start. The datapath is
// loaded on the following edge, when the FSM leaves IDLE. hi/lo only change
// on the edge that enters FIN.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div0
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t state, state_next;

  // Captured request
  logic             pend;
  logic             op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  // Iteration state
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             div0_q;

  // Booth multiplier: 33-bit accumulator, multiplier shift register, Q(-1)
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] mq;
  logic             qm1;
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   acc_nx;
  logic [WIDTH-1:0] mq_nx;
  logic             qm1_nx;

  // Restoring divider: partial remainder and quotient/dividend shift register
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   shifted;
  logic             take;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] quo_fix;
  logic             q_neg;
  logic             r_neg;

  assign last  = (cnt == LAST_ITER);
  assign m_ext = {a_q[WIDTH-1], a_q};
  assign a_mag = a_q[WIDTH-1] ? -a_q : a_q;
  assign b_mag = b_q[WIDTH-1] ? -b_q : b_q;
  assign q_neg = a_q[WIDTH-1] ^ b_q[WIDTH-1];
  assign r_neg = a_q[WIDTH-1];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (pend) begin
          if (!op_q)           state_next = MULT;
          else if (b_q != '0)  state_next = DIV;
          else                 state_next = FIN;
        end
      end
      MULT:    if (last) state_next = FIN;
      DIV:     if (last) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (state == MULT) || (state == DIV);
    done = (state == FIN);
    div0 = (state == FIN) && div0_q;
  end

  // Request capture: start is only looked at in IDLE with nothing pending,
  // so requests during an operation are dropped rather than queued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0;
      op_q <= 1'b0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (state == IDLE) begin
      if (pend) begin
        pend <= 1'b0;
      end else if (start) begin
        pend <= 1'b1;
        op_q <= op;
        a_q  <= a;
        b_q  <= b;
      end
    end
  end

  // Divide-by-zero flag: set only when FIN is entered straight from IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div0_q <= 1'b0;
    else        div0_q <= (state == IDLE) && (state_next == FIN);
  end

  // One Booth step: add/subtract multiplicand per {Q0,Q-1}, then arithmetic
  // shift of the whole {acc, mq, qm1} chain
  always_comb begin
    booth_sum = acc;
    case ({mq[0], qm1})
      2'b01:   booth_sum = acc + m_ext;
      2'b10:   booth_sum = acc - m_ext;
      default: booth_sum = acc;
    endcase
    acc_nx = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    mq_nx  = {booth_sum[0], mq[WIDTH-1:1]};
    qm1_nx = mq[0];
  end

  // One restoring-division step plus the sign fix-up applied on the last one.
  // The remainder never reaches the divisor magnitude, so the low word of
  // the subtraction is exact whenever the subtraction is taken.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    take    = (shifted >= {1'b0, b_mag});
    rem_nx  = take ? (shifted[WIDTH-1:0] - b_mag) : shifted[WIDTH-1:0];
    quo_nx  = {quo[WIDTH-2:0], take};
    quo_fix = q_neg ? -quo_nx : quo_nx;
    rem_fix = r_neg ? -rem_nx : rem_nx;
  end

  // Datapath: load on leaving IDLE, iterate in MULT/DIV, publish on last step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      mq  <= '0;
      qm1 <= 1'b0;
      rem <= '0;
      quo <= '0;
      cnt <= '0;
      hi  <= '0;
      lo  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pend) begin
            acc <= '0;
            mq  <= b_q;
            qm1 <= 1'b0;
            rem <= '0;
            quo <= a_mag;
            cnt <= '0;
          end
        end
        MULT: begin
          acc <= acc_nx;
          mq  <= mq_nx;
          qm1 <= qm1_nx;
          cnt <= cnt + CNT_W'(1);
          if (last) begin
            hi <= acc_nx[WIDTH-1:0];
            lo <= mq_nx;
          end
        end
        DIV: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + CNT_W'(1);
          if (last) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected results with
// the cycle at which done must appear; a monitor pops and compares on done.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        d0;
    int          at;
    int          bc;
  } exp_t;

  exp_t  sb[$];
  string nm_q[$];
  int    cyc = 0;
  int    n_checks = 0;
  int    n_pass = 0;
  int    busy_cnt = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done),
    .div0  (div0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
      $display("check %-22s ok   value=%08h", nm, act);
    end else begin
      $display("FAIL %-22s actual=%08h required=%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Issue one request; expected done appears lat cycles after the sampling edge
  task automatic issue(input logic o, input logic [31:0] aa, input logic [31:0] bb,
                       input logic [31:0] eh, input logic [31:0] el, input logic ed,
                       input int lat, input int bcnt, input string nm);
    exp_t e;
    @(negedge clk);
    op = o; a = aa; b = bb; start = 1'b1;
    e.hi = eh; e.lo = el; e.d0 = ed; e.at = cyc + 1 + lat; e.bc = bcnt;
    sb.push_back(e);
    nm_q.push_back(nm);
    $display("issue %-16s op=%0d a=%08h b=%08h", nm, o, aa, bb);
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    op = 1'($urandom);
  endtask

  task automatic wait_drain(input int limit);
    int k = 0;
    while (sb.size() != 0 && k < limit) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
      nm_q.delete();
    end
  endtask

  // Monitor: compares on every done pulse
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_cnt = 0;
      end else begin
        if (busy) busy_cnt++;
        if (div0 && !done) check("div0_without_done", 32'(div0), 32'd0);
        if (done) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 32'(done), 32'd0);
          end else begin
            e  = sb.pop_front();
            nm = nm_q.pop_front();
            check({nm, ".hi"},      hi,              e.hi);
            check({nm, ".lo"},      lo,              e.lo);
            check({nm, ".div0"},    32'(div0),       32'(e.d0));
            check({nm, ".latency"}, 32'(cyc),        32'(e.at));
            check({nm, ".busy"},    32'(busy_cnt),   32'(e.bc));
          end
          busy_cnt = 0;
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog bench did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   k;
    // Reset state
    #1;
    check("rst.hi",   hi,         32'd0);
    check("rst.lo",   lo,         32'd0);
    check("rst.busy", 32'(busy),  32'd0);
    check("rst.done", 32'(done),  32'd0);
    check("rst.div0", 32'(div0),  32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle.busy", 32'(busy), 32'd0);

    // Directed vectors
    issue(1'b0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33, 32, "mult_7_m3");
    wait_drain(100);
    issue(1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33, 32, "mult_min_min");
    wait_drain(100);
    issue(1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 32, "div_m7_2");
    wait_drain(100);
    issue(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33, 32, "div_min_m1");
    wait_drain(100);
    issue(1'b0, 32'h55555556, 32'h33333333, 32'h11111111, 32'h22222222, 1'b0, 33, 32, "mult_set_hilo");
    wait_drain(100);
    issue(1'b1, 32'h00000005, 32'h00000000, 32'h11111111, 32'h22222222, 1'b1, 1, 0, "div_by_zero");
    wait_drain(100);

    // Start during an operation is ignored
    issue(1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 33, 32, "mult_3_4");
    repeat (9) @(negedge clk);
    op = 1'b1; a = 32'd9; b = 32'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain(100);
    repeat (20) @(negedge clk);

    // Reset in the middle of a divide
    issue(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, 32, "div_aborted");
    repeat (14) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort.hi",   hi,        32'd0);
    check("abort.lo",   lo,        32'd0);
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    sb.delete();
    nm_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post_abort.hi", hi, 32'd0);
    check("post_abort.lo", lo, 32'd0);
    issue(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, 32, "div_100_7");
    wait_drain(100);

    // start held high: re-triggers once back in IDLE, with the new operands
    @(negedge clk);
    op = 1'b0; a = 32'd6; b = 32'd7; start = 1'b1;
    e.hi = 32'd0; e.lo = 32'd42; e.d0 = 1'b0; e.at = cyc + 1 + 33; e.bc = 32;
    sb.push_back(e);
    nm_q.push_back("held_mult_6_7");
    e.hi = 32'hFFFFFFFB; e.lo = 32'd0; e.d0 = 1'b0; e.at = cyc + 1 + 35 + 33; e.bc = 32;
    sb.push_back(e);
    nm_q.push_back("held_div_m5_9");
    $display("issue held_start       mult 6*7 then div -5/9");
    @(negedge clk);
    op = 1'b1; a = 32'hFFFFFFFB; b = 32'd9;
    k = 0;
    while (!(sb.size() <= 1 && busy) && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    start = 1'b0;
    if (k >= 200) check("held_retrigger_timeout", 32'(k), 32'd0);
    wait_drain(100);

    // Results hold after completion
    repeat (5) @(negedge clk);
    check("hold.hi",  hi, 32'hFFFFFFFB);
    check("hold.lo",  lo, 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
